// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if -- bundle of the instruction-fetch signals.
//
// Core side : pc_inc, br_sel, br_addr (into the fetch unit)
//             ir, ir_valid, pc, halted (out of the fetch unit)
// Memory    : mem_req, mem_addr (out of the fetch unit)
//             mem_ack, mem_data (into the fetch unit)
//
// master : the fetch unit (ifetch)
// slave  : the environment around it (core + instruction memory)
// ---------------------------------------------------------------------------
interface ifetch_if;
    logic        pc_inc;
    logic        br_sel;
    logic [15:0] br_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        halted;

    modport master (
        input  pc_inc, br_sel, br_addr, mem_ack, mem_data,
        output mem_req, mem_addr, ir, ir_valid, pc, halted
    );

    modport slave (
        output pc_inc, br_sel, br_addr, mem_ack, mem_data,
        input  mem_req, mem_addr, ir, ir_valid, pc, halted
    );
endinterface

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch unit for the sisc core.
//
// Fetches 32-bit instruction words from a memory with unbounded latency
// (req/ack handshake), presents them to the core in ir/pc/ir_valid, and
// follows sequential advance (pc_inc) or redirection (br_sel/br_addr).
// A word whose top nibble equals HALT_OP stops fetching until reset.
//
// Ports:
//   clk    rising-edge clock
//   rst_f  asynchronous active-high reset
//   bus    ifetch_if.master: pc_inc, br_sel, br_addr (in),
//          mem_req, mem_addr (out), mem_ack, mem_data (in),
//          ir, ir_valid, pc, halted (out)
//
// Parameters:
//   RESET_PC  address of the first instruction fetched after reset
//   HALT_OP   opcode in ir[31:28] that stops fetching
//
// Build option:
//   IFETCH_PREFETCH_EN  when defined, a one-entry prefetch buffer holds the
//                       word at pc+1 so pc_inc can be served without a
//                       memory round trip. Undefined: no buffer, mem_req is
//                       low while holding an instruction.
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ifetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic      clk,
    input  logic      rst_f,
    ifetch_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_r,    state_s;
    logic [31:0] ir_r,       ir_s;
    logic [15:0] pc_r,       pc_s;
    logic        ir_valid_r, ir_valid_s;
    logic        mem_req_r,  mem_req_s;
    logic [15:0] mem_addr_r, mem_addr_s;
    logic        halted_r,   halted_s;
    // squash_r: the outstanding request must be discarded when it completes;
    // tgt_r holds the redirect address to request afterwards.
    logic        squash_r,   squash_s;
    logic [15:0] tgt_r,      tgt_s;

`ifdef IFETCH_PREFETCH_EN
    logic        pf_valid_r, pf_valid_s;
    logic [31:0] pf_data_r,  pf_data_s;
    logic        pf_hit_s;
    logic [31:0] pf_word_s;
`endif

    function automatic logic is_halt(input logic [31:0] word);
        return (word[31:28] == HALT_OP);
    endfunction

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        ir_s       = ir_r;
        pc_s       = pc_r;
        ir_valid_s = ir_valid_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        halted_s   = halted_r;
        squash_s   = squash_r;
        tgt_s      = tgt_r;
`ifdef IFETCH_PREFETCH_EN
        pf_valid_s = pf_valid_r;
        pf_data_s  = pf_data_r;
        // The buffered word is either already stored or arriving right now.
        pf_hit_s   = pf_valid_r | (mem_req_r & bus.mem_ack);
        pf_word_s  = pf_valid_r ? pf_data_r : bus.mem_data;
`endif

        case (state_r)
            IDLE: begin
                mem_req_s  = 1'b1;
                mem_addr_s = RESET_PC;
                state_s    = REQ;
            end

            REQ: begin
                if (bus.mem_ack) begin
                    if (squash_r || bus.br_sel) begin
                        // Redirected fetch: drop the returned word and ask
                        // for the newest target. mem_req stays high.
                        if (bus.br_sel) begin
                            mem_addr_s = bus.br_addr;
                        end else begin
                            mem_addr_s = tgt_r;
                        end
                        squash_s = 1'b0;
                    end else begin
                        ir_s       = bus.mem_data;
                        pc_s       = mem_addr_r;
                        ir_valid_s = 1'b1;
                        if (is_halt(bus.mem_data)) begin
                            state_s   = HALT;
                            halted_s  = 1'b1;
                            mem_req_s = 1'b0;
                        end else begin
                            state_s = HOLD;
`ifdef IFETCH_PREFETCH_EN
                            mem_req_s  = 1'b1;
                            mem_addr_s = mem_addr_r + 16'd1;
                            pf_valid_s = 1'b0;
`else
                            mem_req_s  = 1'b0;
`endif
                        end
                    end
                end else if (bus.br_sel) begin
                    // Address must stay put until the memory answers, so
                    // only remember where to go next.
                    squash_s = 1'b1;
                    tgt_s    = bus.br_addr;
                end else begin
                    squash_s = squash_r;
                end
            end

            HOLD: begin
`ifdef IFETCH_PREFETCH_EN
                if (bus.br_sel) begin
                    pf_valid_s = 1'b0;
                    ir_valid_s = 1'b0;
                    mem_req_s  = 1'b1;
                    state_s    = REQ;
                    if (mem_req_r && !bus.mem_ack) begin
                        // Prefetch still in flight: squash it in REQ.
                        squash_s = 1'b1;
                        tgt_s    = bus.br_addr;
                    end else begin
                        mem_addr_s = bus.br_addr;
                    end
                end else if (bus.pc_inc && ir_valid_r) begin
                    if (pf_hit_s) begin
                        // Serve from the buffer; ir_valid never drops.
                        ir_s       = pf_word_s;
                        pc_s       = pc_r + 16'd1;
                        pf_valid_s = 1'b0;
                        if (is_halt(pf_word_s)) begin
                            state_s   = HALT;
                            halted_s  = 1'b1;
                            mem_req_s = 1'b0;
                        end else begin
                            mem_req_s  = 1'b1;
                            mem_addr_s = pc_r + 16'd2;
                        end
                    end else if (mem_req_r) begin
                        // The pc+1 request is already out; wait for it.
                        ir_valid_s = 1'b0;
                        state_s    = REQ;
                    end else begin
                        mem_req_s  = 1'b1;
                        mem_addr_s = pc_r + 16'd1;
                        ir_valid_s = 1'b0;
                        state_s    = REQ;
                    end
                end else begin
                    if (mem_req_r && bus.mem_ack) begin
                        pf_data_s  = bus.mem_data;
                        pf_valid_s = 1'b1;
                        mem_req_s  = 1'b0;
                    end else begin
                        pf_valid_s = pf_valid_r;
                    end
                end
`else
                if (bus.br_sel) begin
                    mem_req_s  = 1'b1;
                    mem_addr_s = bus.br_addr;
                    ir_valid_s = 1'b0;
                    state_s    = REQ;
                end else if (bus.pc_inc && ir_valid_r) begin
                    mem_req_s  = 1'b1;
                    mem_addr_s = pc_r + 16'd1;
                    ir_valid_s = 1'b0;
                    state_s    = REQ;
                end else begin
                    mem_req_s = 1'b0;
                end
`endif
            end

            HALT: begin
                halted_s  = 1'b1;
                mem_req_s = 1'b0;
            end

            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also abandons any open request.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_r    <= IDLE;
            ir_r       <= 32'h0000_0000;
            pc_r       <= RESET_PC;
            ir_valid_r <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
            halted_r   <= 1'b0;
            squash_r   <= 1'b0;
            tgt_r      <= RESET_PC;
`ifdef IFETCH_PREFETCH_EN
            pf_valid_r <= 1'b0;
            pf_data_r  <= 32'h0000_0000;
`endif
        end else begin
            state_r    <= state_s;
            ir_r       <= ir_s;
            pc_r       <= pc_s;
            ir_valid_r <= ir_valid_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            halted_r   <= halted_s;
            squash_r   <= squash_s;
            tgt_r      <= tgt_s;
`ifdef IFETCH_PREFETCH_EN
            pf_valid_r <= pf_valid_s;
            pf_data_r  <= pf_data_s;
`endif
        end
    end

    assign bus.ir       = ir_r;
    assign bus.ir_valid = ir_valid_r;
    assign bus.pc       = pc_r;
    assign bus.halted   = halted_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, address of the first instruction fetched after reset.
REQ-002 Parameter: HALT_OP, default 4'hF, opcode value in ir[31:28] that stops fetching.
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-high, port rst_f.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_f  input  1  asynchronous active-high reset (port name kept for codebase consistency; asserted = 1).
REQ-006 Port: pc_inc  input  1  core accepted current ir; advance to pc+1.
REQ-007 Port: br_sel  input  1  core redirects fetch to br_addr.
REQ-008 Port: br_addr  input  16  branch target.
REQ-009 Port: mem_req  output  1  instruction memory read request.
REQ-010 Port: mem_addr  output  16  read address; stable while mem_req=1.
REQ-011 Port: mem_ack  input  1  read data valid on mem_data this cycle.
REQ-012 Port: mem_data  input  32  instruction word.
REQ-013 Port: ir  output  32  instruction register driven to the sisc core.
REQ-014 Port: ir_valid  output  1  ir holds a valid instruction.
REQ-015 Port: pc  output  16  address of the instruction in ir.
REQ-016 Port: halted  output  1  HALT_OP instruction reached; fetch stopped.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, HOLD, HALT.
REQ-018 IDLE: one cycle after reset release; drives mem_req=1, mem_addr=RESET_PC; goes to REQ.
REQ-019 REQ: mem_req=1 until mem_ack; on mem_ack, ir<=mem_data, pc<=mem_addr, ir_valid<=1, next state HOLD (HALT if mem_data[31:28]==HALT_OP).
REQ-020 Memory latency is unbounded; mem_addr and mem_req SHALL NOT change in REQ except per REQ-024.
REQ-021 HOLD: ir, pc held; pc_inc=1 starts a fetch of pc+1 (ir_valid<=0, state REQ) next cycle.
REQ-022 HOLD: br_sel=1 starts a fetch of br_addr; br_sel wins over simultaneous pc_inc.
REQ-023 Address arithmetic is modulo 2^16: pc 16'hFFFF + 1 = 16'h0000.
REQ-024 br_sel in REQ SHALL squash the pending fetch: a squash flag is set and mem_req stays high at the old address until mem_ack; that data is discarded and the target is then requested; a later br_sel replaces the stored target.
REQ-025 br_sel and mem_ack in the same REQ cycle: data discarded, target requested next cycle.
REQ-026 HALT: halted=1, mem_req=0, ir/pc/ir_valid held; pc_inc ignored; br_sel ignored; exit only by reset.
REQ-027 pc_inc while ir_valid=0 SHALL be ignored.
REQ-028 ir_valid rises exactly one cycle after the accepted mem_ack (registered outputs).

Reset
REQ-029 rst_f=1 SHALL immediately force: state IDLE, ir=32'h0, ir_valid=0, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, halted=0, squash flag clear.
REQ-030 Reset during REQ SHALL drop mem_req asynchronously; a mem_ack arriving during or after reset for the old request is ignored.

Configuration
REQ-031 Macro IFETCH_PREFETCH_EN compiles in a one-entry prefetch buffer.
REQ-032 With IFETCH_PREFETCH_EN: in HOLD the block fetches pc+1 into the buffer; pc_inc with a full buffer loads ir from it in the next cycle with ir_valid continuously 1 and no new REQ wait; br_sel or reset invalidates the buffer (in-flight prefetch squashed per REQ-024); a buffered HALT_OP word enters HALT only when moved into ir.
REQ-033 Without IFETCH_PREFETCH_EN: no buffer, mem_req=0 in HOLD, behaviour exactly REQ-017..REQ-028.

Verification
REQ-034 Reset, mem_ack 3 cycles after each req, mem[0]=32'h1000_0001 -> mem_addr=0000, then ir=32'h1000_0001, pc=0000, ir_valid=1.
REQ-035 pc_inc pulse in HOLD with pc=16'hFFFF -> mem_addr=16'h0000, pc=16'h0000 after ack.
REQ-036 br_sel=1, br_addr=16'h0040 during REQ for 0005 -> word at 0005 discarded, mem_addr=0040, ir=mem[0040], pc=0040.
REQ-037 br_sel and pc_inc together in HOLD, br_addr=16'h0010 -> next mem_addr=0010.
REQ-038 mem[0002]=32'hF000_0000 -> halted=1, mem_req=0, pc=0002 held; further pc_inc/br_sel no effect.
REQ-039 rst_f=1 mid-REQ then mem_ack -> mem_req=0 immediately, ir=0, ir_valid=0, pc=RESET_PC; fetch restarts at RESET_PC after release.
